dmem_responder: RTL
===================

# dmem_responder

Multi-cycle data-memory responder answering the pipeline memory stage's access requests (enable/wr/addr/data_in, with a createdump strobe). It accepts one request at a time and holds `stall` high while busy. After a programmable latency it completes the access with a one-cycle `done` pulse. It replaces the single-cycle memory so the pipeline's stall logic can be exercised against a realistic responder.

## Interface
- `LATENCY`, default 2: cycles from request acceptance to `done`; legal range 1..15.
- `ADDR_W`, default 10: word-index width; storage is 2^ADDR_W 16-bit words.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `enable` input 1: request valid; held by initiator while `stall`=1.
- `wr` input 1: 1 = write, 0 = read; qualified by `enable`.
- `addr` input 16: byte address; word index = `addr[ADDR_W:1]`; upper bits ignored.
- `data_in` input 16: write data.
- `createdump` input 1: dump request; accepted only in IDLE.
- `data_out` output 16: read data; valid only while `done`=1, 0 otherwise.
- `stall` output 1: request pending, initiator must hold inputs.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: unaligned-access flag, coincident with `done` (see Configuration).

## Operation
- States: IDLE, BUSY, DONE.
- IDLE
  - `stall` = `enable` (combinational).
  - On `enable`=1: capture `wr`, word index, `data_in`, and alignment flag; load 4-bit counter with LATENCY-1.
  - If LATENCY=1, go to DONE; otherwise go to BUSY.
- BUSY
  - `stall`=1.
  - Counter decrements each cycle; at 1 → DONE. Inputs are ignored (captured copies used).
- DONE
  - `done`=1, `stall`=0.
  - Read: `data_out` = word at captured index.
  - Write: array updated at the end of the DONE cycle.
  - Next state is always IDLE; `enable` is ignored in DONE because the initiator is still presenting the completed request.
- Read data is registered at the BUSY/IDLE→DONE edge, so a write committed in a prior DONE is visible to the next read.
- `createdump` in IDLE with `enable`=0 sets a sticky dump flag for simulation hooks. Otherwise it is ignored. No effect on handshake.
- Reset (any time, including mid-BUSY):
  - State → IDLE; counter 0; `stall`, `done`, `err` = 0; `data_out` = 0.
  - Pending write is discarded; array contents are not altered.

## Timing
- Request seen in IDLE at cycle T: `stall`=1 in cycles T..T+LATENCY-1; `done`=1 at T+LATENCY.
- Next request is accepted no earlier than T+LATENCY+1; throughput is one access per LATENCY+1 cycles.
- `enable` deasserted mid-BUSY has no effect; the captured access completes.
- Reset values: all outputs 0 and held while `rst`=0; first acceptance possible in the first cycle after `rst` deasserts.

## Configuration
- Macro `DMEM_ALIGN_CHECK_EN`.
- Defined: `addr[0]`=1 completes with normal latency, `err`=1 with `done`, no write, `data_out`=0.
- Undefined: `addr[0]` is ignored, `err` is tied 0, and the access proceeds on the word index.

## Structure
- Shared package `dmem_pkg`: state enum (IDLE/BUSY/DONE), `WORD_W`=16, `CNT_W`=4.
- One sub-module `dmem_array`:
  - 2^ADDR_W×16 storage.
  - Synchronous write with write-enable.
  - Registered read port.
  - No reset on contents.
- FSM, counter, capture registers, and alignment check live in `dmem_responder`.

## Test plan
- Reset mid-BUSY: write 0x00FF to 0x0030, assert `rst`=0 while `stall`=1 → outputs 0 immediately; subsequent read of 0x0030 does not return 0x00FF.
- Write/read: write 0x1234 to addr 0x0010, then read 0x0010 (LATENCY=2) → `stall` high 2 cycles, `done` in the 3rd, `data_out`=0x1234.
- Latency sweep: LATENCY=1 and LATENCY=15 → `done` exactly LATENCY cycles after acceptance; `stall` never high in a DONE cycle.
- Held `enable` through DONE: read 0x0020 with `enable` held one extra cycle → exactly one `done` pulse, no second access.
- Input change while busy: write 0xBEEF to 0x0040, change `data_in` to 0x0000 during BUSY → readback 0xBEEF.
- Unaligned: with `DMEM_ALIGN_CHECK_EN`, write 0xAAAA to 0x0011 → `err`=1 with `done`; read 0x0010 returns its prior value. Without the macro, same write lands at word 0x0010.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline memory stage (master) and the responder (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic              enable;
    logic              wr;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data_in;
    logic              createdump;
    logic [WORD_W-1:0] data_out;
    logic              stall;
    logic              done;
    logic              err;

    modport master (
        output enable, wr, addr, data_in, createdump,
        input  data_out, stall, done, err
    );

    modport slave (
        input  enable, wr, addr, data_in, createdump,
        output data_out, stall, done, err
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage for the responder: synchronous write, registered read, contents never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [WORD_W-1:0] mem_q [Depth];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one access at a time, stall while busy, done after LATENCY.
// Optional unaligned-access flagging is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              mis_q, mis_d;
    logic              dump_q, dump_d;

    logic [ADDR_W-1:0] in_idx;
    logic              in_mis;
    logic [ADDR_W-1:0] rd_idx;
    logic [WORD_W-1:0] rdata;
    logic              mem_we;

    assign in_idx = bus.addr[ADDR_W:1];

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_mis = bus.addr[0];
`else
    logic unused_addr_lsb;
    assign in_mis          = 1'b0;
    assign unused_addr_lsb = bus.addr[0];
`endif

    if (ADDR_W + 1 < WORD_W) begin : g_unused_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^bus.addr[WORD_W-1:ADDR_W+1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        dump_d  = dump_q;

        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    wr_d    = bus.wr;
                    idx_d   = in_idx;
                    wdata_d = bus.data_in;
                    mis_d   = in_mis;
                    cnt_d   = CntLoad;
                    state_d = (LATENCY == 1) ? StDone : StBusy;
                end else if (bus.createdump) begin
                    dump_d = 1'b1;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                end
            end
            // The initiator still presents the finished request here, so enable is ignored.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // Read port samples the live index on the accepting edge so LATENCY=1 still has data.
        rd_idx       = (state_q == StIdle) ? in_idx : idx_q;
        mem_we       = (state_q == StDone) && wr_q && !mis_q;
        bus.stall    = (state_q == StIdle) ? (bus.enable & rst) : (state_q == StBusy);
        bus.done     = (state_q == StDone);
        bus.data_out = ((state_q == StDone) && !wr_q && !mis_q) ? rdata : '0;
`ifdef DMEM_ALIGN_CHECK_EN
        bus.err      = (state_q == StDone) && mis_q;
`else
        bus.err      = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            mis_q   <= 1'b0;
            dump_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            dump_q  <= dump_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .raddr_i (rd_idx),
        .rdata_o (rdata)
    );

endmodule
